load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of addr and mem_addr.
REQ-002 Parameter: TIMEOUT, 16, maximum cycles spent in REQ before a fault; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request from the control FSM.
REQ-006 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-007 funct3  in  3  RV32I width/sign code; sampled with start.
REQ-008 addr  in  ADDR_W  effective byte address (ALU result); sampled with start.
REQ-009 store_data  in  32  rs2 value; sampled with start.
REQ-010 mem_ready  in  1  memory accepts the request / read data valid.
REQ-011 mem_rdata  in  32  memory read word; valid when mem_ready=1.
REQ-012 busy  out  1  high in every non-IDLE state.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 fault  out  1  valid only with done; 1 = misaligned, illegal funct3, or timeout.
REQ-015 load_data  out  32  extended load result; held until the next done.
REQ-016 mem_req  out  1  memory request.
REQ-017 mem_we  out  1  write enable.
REQ-018 mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
REQ-019 mem_wdata  out  32  lane-replicated store data.
REQ-020 mem_be  out  4  byte enables.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-022 In IDLE, start=1 SHALL register is_store, funct3, addr, store_data and an offset off=addr[1:0].
REQ-023 On that start edge, a legal and aligned access SHALL go to REQ; any other access SHALL go to DONE with fault=1 and SHALL never assert mem_req.
REQ-024 Legal load funct3 codes SHALL be 0 LB, 1 LH, 2 LW, 4 LBU and 5 LHU.
REQ-025 Legal store funct3 codes SHALL be 0 SB, 1 SH and 2 SW.
REQ-026 Alignment SHALL require off[0]=0 for halfword accesses and off=0 for word accesses.
REQ-027 In REQ, mem_req SHALL be 1, mem_we SHALL equal the registered is_store, and mem_addr, mem_wdata and mem_be SHALL stay stable until mem_ready=1.
REQ-028 A rising edge in REQ with mem_ready=1 SHALL capture read data, move to DONE, and deassert mem_req in the next cycle.
REQ-029 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-030 Latency: start at edge t with mem_ready already high gives mem_req in cycle t+1 and done in cycle t+2; each cycle of mem_ready low adds one cycle.
REQ-031 start SHALL be ignored while busy=1, including in DONE.
REQ-032 Byte enables: SB gives mem_be=4'b0001<<off; SH gives 4'b0011<<off; SW gives 4'b1111.
REQ-033 mem_be SHALL be 4'b0000 whenever mem_req=0.
REQ-034 Store data: SB replicates store_data[7:0] into all four lanes; SH replicates [15:0] into both halves; SW passes the word unchanged.
REQ-035 Loads: the selected lane is mem_rdata[8*off+7:8*off] for bytes and [8*off+15:8*off] for halves.
REQ-036 LB and LH SHALL sign-extend the selected lane to 32 bits; LBU and LHU SHALL zero-extend; LW SHALL pass the word.
REQ-037 For stores and for faulted accesses, load_data SHALL keep its previous value.
REQ-038 A cycle counter SHALL clear on entry to REQ and increment every REQ cycle with mem_ready=0.
REQ-039 If TIMEOUT≠0 and the counter reaches TIMEOUT, the FSM SHALL go to DONE with fault=1 and load_data unchanged.
REQ-040 If mem_ready=1 in the same cycle the counter reaches TIMEOUT, mem_ready SHALL win: normal completion with fault=0.

Reset
REQ-041 reset=0 SHALL immediately force IDLE, busy=0, done=0, fault=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0 and counter=0, without waiting for clk.
REQ-042 Reset asserted mid-transaction SHALL abort the transaction with no done pulse.
REQ-043 Operation SHALL resume on the first rising edge after reset returns to 1.

Verification
REQ-044 LB, addr=0x1003, mem_rdata=0x80FF_1234, mem_ready=1 -> mem_addr=0x1000, mem_be=0, load_data=0xFFFF_FF80, done at t+2, fault=0.
REQ-045 SH, addr=0x2002, store_data=0xDEAD_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF; stable while mem_ready is held low for 3 cycles; done at t+5.
REQ-046 LW at addr=0x3001 -> no mem_req, done at t+1 with fault=1, load_data unchanged.
REQ-047 TIMEOUT=4, LHU with mem_ready held low -> done with fault=1 after 4 REQ cycles; mem_req=0 afterwards.
REQ-048 start pulsed during REQ and DONE -> ignored, exactly one done per accepted start.
REQ-049 reset driven low while in REQ, mid-cycle -> mem_req and busy drop asynchronously, no done; after release, LBU at off=2 with mem_rdata=0x00AB_0000 -> load_data=0x0000_00AB.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: a three-state IDLE/REQ/DONE sequencer between the core and a
// ready-handshake memory port, with lane steering, sign/zero extension and a request timeout.
module load_store_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [31:0]       load_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be
);

   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state_r, state_s;
   logic              is_store_r;
   logic [2:0]        funct3_r;
   logic [1:0]        off_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic [3:0]        be_r;
   logic [31:0]       load_data_r;
   logic              fault_r;
   logic [CNT_W-1:0]  cnt_r;

   logic              fault_s;
   logic              capture_s;
   logic              load_en_s;
   logic              cnt_inc_s;
   logic [CNT_W-1:0]  cnt_plus_s;
   logic              timeout_hit_s;

   function automatic logic access_ok(input logic st, input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'd0:    ok = 1'b1;
         3'd1:    ok = ~off[0];
         3'd2:    ok = (off == 2'b00);
         3'd4:    ok = ~st;
         3'd5:    ok = ~st & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (f3[1:0])
         2'd0:    be = 4'b0001 << off;
         2'd1:    be = 4'b0011 << off;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      w = d;
      case (f3[1:0])
         2'd0:    w = {4{d[7:0]}};
         2'd1:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] r;
      sh = rdata >> {off, 3'b000};
      r  = rdata;
      case (f3)
         3'd0:    r = {{24{sh[7]}}, sh[7:0]};
         3'd1:    r = {{16{sh[15]}}, sh[15:0]};
         3'd2:    r = rdata;
         3'd4:    r = {24'h000000, sh[7:0]};
         3'd5:    r = {16'h0000, sh[15:0]};
         default: r = rdata;
      endcase
      return r;
   endfunction

   assign cnt_plus_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   assign timeout_hit_s = TO_EN && (cnt_plus_s == TO_V);

   // Next-state decode; mem_ready is tested before the timeout so a late response still completes.
   always_comb begin
      state_s   = state_r;
      fault_s   = 1'b0;
      capture_s = 1'b0;
      load_en_s = 1'b0;
      cnt_inc_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               capture_s = 1'b1;
               if (access_ok(is_store, funct3, addr[1:0])) begin
                  state_s = REQ;
               end else begin
                  state_s = DONE;
                  fault_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (mem_ready) begin
               state_s   = DONE;
               load_en_s = ~is_store_r;
            end else if (timeout_hit_s) begin
               state_s   = DONE;
               fault_s   = 1'b1;
               cnt_inc_s = 1'b1;
            end else begin
               state_s   = REQ;
               cnt_inc_s = 1'b1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, request capture, counter and load result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         is_store_r  <= 1'b0;
         funct3_r    <= 3'd0;
         off_r       <= 2'd0;
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= 32'h0000_0000;
         be_r        <= 4'b0000;
         load_data_r <= 32'h0000_0000;
         fault_r     <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         fault_r <= fault_s;
         if (capture_s) begin
            is_store_r <= is_store;
            funct3_r   <= funct3;
            off_r      <= addr[1:0];
            addr_r     <= {addr[ADDR_W-1:2], 2'b00};
            wdata_r    <= store_lanes(funct3, store_data);
            be_r       <= is_store ? store_be(funct3, addr[1:0]) : 4'b0000;
            cnt_r      <= {CNT_W{1'b0}};
         end else if (cnt_inc_s) begin
            cnt_r <= cnt_plus_s;
         end
         if (load_en_s) begin
            load_data_r <= load_extend(funct3_r, off_r, mem_rdata);
         end
      end
   end

   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);
   assign fault     = fault_r;
   assign mem_req   = (state_r == REQ);
   assign mem_we    = mem_req & is_store_r;
   assign mem_be    = mem_req ? be_r : 4'b0000;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign load_data = load_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses compared
// against an arithmetic reference model of the RV32I load/store rules.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        busy, done, fault, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_load = 32'h0;

   load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .store_data(store_data), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .fault(fault), .load_data(load_data), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      int f;
      f = int'(f3) % 4;
      if (f == 0) return 1;
      if (f == 1) return 2;
      return 4;
   endfunction

   function automatic bit legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
      int f;
      bit code_ok;
      f = int'(f3);
      code_ok = st ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
      return code_ok && ((a % 4) % size_of(f3) == 0);
   endfunction

   function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
      int v;
      if (!st) return 4'b0000;
      v = ((1 << size_of(f3)) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (size_of(f3) == 1) return (sd & 32'h0000_00FF) * 32'h0101_0101;
      if (size_of(f3) == 2) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
      longint v;
      int n;
      n = 8 * size_of(f3);
      v = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << n) - 64'd1);
      if (int'(f3) < 4 && v >= longint'(64'd1 << (n - 1))) v = v - longint'(64'd1 << n);
      return v[31:0];
   endfunction

   task automatic noise(input bit noisy);
      start = noisy;
      if (noisy) begin
         is_store   = 1'($urandom_range(0, 1));
         funct3     = 3'($urandom_range(0, 7));
         addr       = $urandom;
         store_data = $urandom;
      end else begin
         start = 1'b0;
      end
   endtask

   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int low, input bit noisy);
      bit ok;
      bit got;
      ok  = legal(st, f3, a);
      got = 1'b0;
      @(negedge clk);
      start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_ready = 1'b0;
      @(negedge clk);
      if (!ok) begin
         noise(noisy);
         chk("flt_done", 32'(done), 32'd1);
         chk("flt_fault", 32'(fault), 32'd1);
         chk("flt_busy", 32'(busy), 32'd1);
         chk("flt_req", 32'(mem_req), 32'd0);
         chk("flt_be", 32'(mem_be), 32'd0);
         chk("flt_load", load_data, exp_load);
      end else begin
         for (int k = 0; k < TO; k++) begin
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_req", 32'(mem_req), 32'd1);
            chk("req_done", 32'(done), 32'd0);
            chk("req_we", 32'(mem_we), 32'(st));
            chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("req_be", 32'(mem_be), 32'(model_be(st, f3, a)));
            if (st) chk("req_wdata", mem_wdata, model_wdata(f3, sd));
            noise(noisy);
            mem_ready = (k == low);
            mem_rdata = (k == low) ? rd : $urandom;
            @(negedge clk);
            if (k == low) begin
               got = 1'b1;
               break;
            end
         end
         mem_ready = 1'b0;
         if (!st && got) exp_load = model_load(f3, a, rd);
         noise(noisy);
         chk("end_done", 32'(done), 32'd1);
         chk("end_fault", 32'(fault), 32'(!got));
         chk("end_req", 32'(mem_req), 32'd0);
         chk("end_load", load_data, exp_load);
      end
      @(negedge clk);
      start = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_be", 32'(mem_be), 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_load", load_data, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      do_op(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
      chk("lb_value", load_data, 32'hFFFF_FF80);
      do_op(1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
      do_op(1'b0, 3'd2, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, 1'b0);
      chk("lw_mis_keep", load_data, 32'hFFFF_FF80);
      do_op(1'b0, 3'd5, 32'h0000_4002, 32'h0, 32'hAAAA_5555, 10, 1'b0);
      do_op(1'b0, 3'd1, 32'h0000_5006, 32'h0, 32'h8001_0000, 2, 1'b1);

      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = 3'd5; addr = 32'h0000_6000; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("mid_req_pre", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_req", 32'(mem_req), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_load", load_data, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_nodone", 32'(done), 32'd0);
      end
      reset = 1'b1;
      exp_load = 32'h0;
      do_op(1'b0, 3'd4, 32'h0000_7002, 32'h0, 32'h00AB_0000, 0, 1'b0);
      chk("lbu_value", load_data, 32'h0000_00AB);

      for (int i = 0; i < 80; i++) begin
         do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
               int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
